imuldiv_muldiv_arbiter: RTL

//  Shares one imuldiv_IntMulDivIterative unit between two requesters, e.g. two issue ports.

---
 rtl/imuldiv_muldiv_arbiter_pkg.sv | 28 ++
 rtl/imuldiv_muldiv_arbiter_if.sv | 32 +++
 rtl/imuldiv_muldiv_tag_queue.sv | 65 ++++++
 rtl/imuldiv_muldiv_arbiter.sv | 97 +++++++++
 4 files changed

// File: rtl/imuldiv_muldiv_arbiter_pkg.sv
// Shared constants and types for the two-port muldiv arbiter.
//   - function encodings of the muldiv request
//   - request/response message widths (67 / 64)
//   - port count and owner tag width
package imuldiv_muldiv_arbiter_pkg;

   localparam int IMULDIV_PORTS = 2;
   localparam int TAG_W         = 1;
   localparam int FN_W          = 3;
   localparam int DATA_W        = 32;
   localparam int REQ_MSG_W     = FN_W + 2 * DATA_W;
   localparam int RESP_MSG_W    = 2 * DATA_W;

   typedef enum logic [FN_W-1:0] {
      FN_MUL  = 3'd0,
      FN_DIV  = 3'd1,
      FN_DIVU = 3'd2,
      FN_REM  = 3'd3,
      FN_REMU = 3'd4
   } muldiv_fn_e;

   typedef logic [TAG_W-1:0] port_tag_t;

   function automatic port_tag_t other_port(input port_tag_t p);
      return ~p;
   endfunction

endpackage

// File: rtl/imuldiv_muldiv_arbiter_if.sv
// Request/response channel pair of one muldiv port.
//   req_msg_fn/a/b, req_val, req_rdy : request message and handshake
//   resp_msg_result, resp_val, resp_rdy : 64-bit result and handshake
// master: the side that issues requests and consumes results.
// slave : the side that executes requests and returns results.
interface imuldiv_muldiv_arbiter_if;
   import imuldiv_muldiv_arbiter_pkg::*;

   logic [FN_W-1:0]       req_msg_fn;
   logic [DATA_W-1:0]     req_msg_a;
   logic [DATA_W-1:0]     req_msg_b;
   logic                  req_val;
   logic                  req_rdy;
   logic [RESP_MSG_W-1:0] resp_msg_result;
   logic                  resp_val;
   logic                  resp_rdy;

   modport master (
      output req_msg_fn, req_msg_a, req_msg_b, req_val,
      input  req_rdy,
      input  resp_msg_result, resp_val,
      output resp_rdy
   );

   modport slave (
      input  req_msg_fn, req_msg_a, req_msg_b, req_val,
      output req_rdy,
      output resp_msg_result, resp_val,
      input  resp_rdy
   );

endinterface

// File: rtl/imuldiv_muldiv_tag_queue.sv
// In-order owner tag queue: DEPTH-entry circular FIFO of port tags.
//   clk, reset          : clock, async active-high reset
//   push / push_tag     : enqueue the owner of an accepted request
//   pop                 : dequeue the head when its result is delivered
//   head_tag            : owner of the oldest outstanding request
//   full / empty / count: occupancy status
// A push while full or a pop while empty is ignored, so count never wraps.
module imuldiv_muldiv_tag_queue
   import imuldiv_muldiv_arbiter_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  port_tag_t        push_tag,
   input  logic             pop,
   output port_tag_t        head_tag,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   port_tag_t        slots_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full     = (cnt_q == CNT_W'(DEPTH));
   assign empty    = (cnt_q == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign head_tag = slots_q[rd_ptr_q];
   assign count    = cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < DEPTH; i++) slots_q[i] <= '0;
      end else begin
         if (do_push) begin
            slots_q[wr_ptr_q] <= push_tag;
            wr_ptr_q          <= ptr_inc(wr_ptr_q);
         end
         if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/imuldiv_muldiv_arbiter.sv
// Shares one iterative muldiv unit between two requesters.
//   clk, reset : clock, async active-high reset (shared with the unit)
//   port0/1    : requester channels (slave side)
//   unit       : channel to the shared muldiv unit (master side)
//   inflight   : number of accepted requests still awaiting their result
// Requests are granted round-robin; the owner of each accepted request is
// queued so results are steered back to their issuer in order. Both paths
// are purely combinational, adding no latency.
module imuldiv_muldiv_arbiter
   import imuldiv_muldiv_arbiter_pkg::*;
#(
   parameter int MAX_INFLIGHT = 2,
   parameter int CNT_W        = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   imuldiv_muldiv_arbiter_if.slave  port0,
   imuldiv_muldiv_arbiter_if.slave  port1,
   imuldiv_muldiv_arbiter_if.master unit,
   output logic [CNT_W-1:0]         inflight
);

   port_tag_t  prio_q;
   port_tag_t  hold_port_q;
   logic       hold_q;
   port_tag_t  grant;
   port_tag_t  head;
   logic [1:0] val_vec;
   logic       grant_val;
   logic       full;
   logic       empty;
   logic       req_fire;
   logic       resp_fire;

   assign val_vec = {port1.req_val, port0.req_val};

   // A port that was granted but not yet accepted keeps the grant, so a
   // late-arriving pointer port cannot steal it mid-handshake.
   always_comb begin
      grant = prio_q;
      if (hold_q && val_vec[hold_port_q]) begin
         grant = hold_port_q;
      end else if (val_vec[prio_q]) begin
         grant = prio_q;
      end else if (val_vec[other_port(prio_q)]) begin
         grant = other_port(prio_q);
      end
   end

   assign grant_val = val_vec[grant];

   // Full blocks the grant even if the head pops this cycle.
   assign unit.req_val    = grant_val && !full;
   assign unit.req_msg_fn = (grant == 1'b1) ? port1.req_msg_fn : port0.req_msg_fn;
   assign unit.req_msg_a  = (grant == 1'b1) ? port1.req_msg_a  : port0.req_msg_a;
   assign unit.req_msg_b  = (grant == 1'b1) ? port1.req_msg_b  : port0.req_msg_b;

   assign port0.req_rdy = grant_val && (grant == 1'b0) && unit.req_rdy && !full;
   assign port1.req_rdy = grant_val && (grant == 1'b1) && unit.req_rdy && !full;

   assign port0.resp_val        = unit.resp_val && !empty && (head == 1'b0);
   assign port1.resp_val        = unit.resp_val && !empty && (head == 1'b1);
   assign port0.resp_msg_result = unit.resp_msg_result;
   assign port1.resp_msg_result = unit.resp_msg_result;
   assign unit.resp_rdy         = !empty && ((head == 1'b1) ? port1.resp_rdy : port0.resp_rdy);

   assign req_fire  = unit.req_val && unit.req_rdy;
   assign resp_fire = unit.resp_val && unit.resp_rdy;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prio_q      <= '0;
         hold_q      <= 1'b0;
         hold_port_q <= '0;
      end else begin
         if (req_fire) prio_q <= other_port(grant);
         hold_q      <= grant_val && !req_fire;
         hold_port_q <= grant;
      end
   end

   imuldiv_muldiv_tag_queue #(
      .DEPTH (MAX_INFLIGHT),
      .CNT_W (CNT_W)
   ) u_tag_queue (
      .clk      (clk),
      .reset    (reset),
      .push     (req_fire),
      .push_tag (grant),
      .pop      (resp_fire),
      .head_tag (head),
      .full     (full),
      .empty    (empty),
      .count    (inflight)
   );

endmodule
